pipelined_addsub: RTL and testbench

- Parametrised, pipelined two's-complement adder/subtractor; successor to the fixed 4-bit ripple adder.
- Splits a WIDTH-bit add into CHUNK-bit ripple slices, one pipeline stage per slice, with the carry registered between stages.
- Valid/ready handshake on both sides, so the block sits directly in datapath streams (ALU, accumulators).
- Adds subtract mode, a signed-overflow flag and backpressure, none of which the ripple adder has.

---
 rtl/pipelined_addsub_pkg.sv | 12 +
 rtl/pipelined_addsub_if.sv | 29 ++
 rtl/pipelined_addsub_adder_chunk.sv | 26 ++
 rtl/pipelined_addsub.sv | 130 +++++++++++++
 tb/tb_pipelined_addsub.sv | 210 +++++++++++++++++++++
 5 files changed

// File: rtl/pipelined_addsub_pkg.sv
// addsub_pkg: shared constants for the pipelined adder/subtractor.
// Mode encoding and the WIDTH/CHUNK legality check.
package addsub_pkg;

  localparam logic MODE_ADD = 1'b0;
  localparam logic MODE_SUB = 1'b1;

  function automatic bit chunk_ok(input int width, input int chunk);
    return (chunk > 0) && (width >= chunk) && (width % chunk == 0);
  endfunction

endpackage

// File: rtl/pipelined_addsub_if.sv
// addsub_if: operand and result streams of the adder/subtractor.
// master drives operands and result ready; slave is the datapath.
interface addsub_if #(
  parameter int WIDTH = 16
) ();

  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a;
  logic [WIDTH-1:0] b;
  logic             cin;
  logic             sub;
  logic             out_valid;
  logic             out_ready;
  logic [WIDTH-1:0] sum;
  logic             cout;
  logic             ovf;

  modport master (
    output in_valid, a, b, cin, sub, out_ready,
    input  in_ready, out_valid, sum, cout, ovf
  );

  modport slave (
    input  in_valid, a, b, cin, sub, out_ready,
    output in_ready, out_valid, sum, cout, ovf
  );

endinterface

// File: rtl/pipelined_addsub_adder_chunk.sv
// adder_chunk: combinational CHUNK-bit ripple of full-adder cells.
// Also exposes the carry into its MSB for overflow detection.
module adder_chunk #(
  parameter int CHUNK = 4
) (
  input  logic [CHUNK-1:0] a,
  input  logic [CHUNK-1:0] b,
  input  logic             cin,
  output logic [CHUNK-1:0] s,
  output logic             cout,
  output logic             cmsb
);

  logic [CHUNK:0] cy;

  assign cy[0] = cin;

  for (genvar i = 0; i < CHUNK; i++) begin : g_fa
    assign s[i]    = a[i] ^ b[i] ^ cy[i];
    assign cy[i+1] = (a[i] & b[i]) | (cy[i] & (a[i] ^ b[i]));
  end

  assign cout = cy[CHUNK];
  assign cmsb = cy[CHUNK-1];

endmodule

// File: rtl/pipelined_addsub.sv
// pipelined_addsub: chunked two's-complement adder/subtractor.
// One stage per CHUNK bits, carry registered between stages.
module pipelined_addsub
  import addsub_pkg::*;
#(
  parameter int WIDTH = 16,
  parameter int CHUNK = 4
) (
  input logic      clk,
  input logic      rst_n,
  addsub_if.slave  bus
);

  localparam int STAGES = WIDTH / CHUNK;

  if (!chunk_ok(WIDTH, CHUNK)) begin : g_bad_cfg
    $error("WIDTH must be a positive multiple of CHUNK");
  end

  logic             en;
  logic             c0;
  logic [WIDTH-1:0] beff;

  // whole pipe advances together; bubbles are held, not squeezed
  assign en           = !g_st[STAGES-1].v_q | bus.out_ready;
  assign bus.in_ready = en;

  assign beff = (bus.sub == MODE_SUB) ? ~bus.b : bus.b;
  assign c0   = (bus.sub == MODE_SUB) ? 1'b1 : bus.cin;

  for (genvar k = 0; k < STAGES; k++) begin : g_st
    localparam int LO = k * CHUNK;
    localparam int HI = WIDTH - LO;

    logic [HI-1:0]       a_in;
    logic [HI-1:0]       b_in;
    logic                c_in;
    logic                v_in;
    logic [CHUNK-1:0]    s;
    logic                co;
    logic [LO+CHUNK-1:0] r_d;
    logic [LO+CHUNK-1:0] r_q;
    logic                v_q;
    logic                c_q;

    if (k == 0) begin : g_in
      assign a_in = bus.a;
      assign b_in = beff;
      assign c_in = c0;
      assign v_in = bus.in_valid;
      assign r_d  = s;
    end else begin : g_in
      assign a_in = g_st[k-1].g_mid.a_q;
      assign b_in = g_st[k-1].g_mid.b_q;
      assign c_in = g_st[k-1].c_q;
      assign v_in = g_st[k-1].v_q;
      assign r_d  = {s, g_st[k-1].r_q};
    end

    // stage valid, carry and deskewed result chunks
    always_ff @(posedge clk) begin
      if (!rst_n) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        r_q <= '0;
      end else if (en) begin
        v_q <= v_in;
        c_q <= co;
        r_q <= r_d;
      end
    end

    if (k == STAGES - 1) begin : g_last
      logic cm;
      logic ovf_q;

      adder_chunk #(
        .CHUNK (CHUNK)
      ) u_add (
        .a    (a_in[CHUNK-1:0]),
        .b    (b_in[CHUNK-1:0]),
        .cin  (c_in),
        .s    (s),
        .cout (co),
        .cmsb (cm)
      );

      // signed overflow from the carries around the MSB
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          ovf_q <= 1'b0;
        end else if (en) begin
          ovf_q <= co ^ cm;
        end
      end
    end else begin : g_mid
      logic                cm_unused;
      logic [HI-CHUNK-1:0] a_q;
      logic [HI-CHUNK-1:0] b_q;

      adder_chunk #(
        .CHUNK (CHUNK)
      ) u_add (
        .a    (a_in[CHUNK-1:0]),
        .b    (b_in[CHUNK-1:0]),
        .cin  (c_in),
        .s    (s),
        .cout (co),
        .cmsb (cm_unused)
      );

      // upper operand chunks skewed to meet their carry
      always_ff @(posedge clk) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (en) begin
          a_q <= a_in[HI-1:CHUNK];
          b_q <= b_in[HI-1:CHUNK];
        end
      end
    end
  end

  assign bus.out_valid = g_st[STAGES-1].v_q;
  assign bus.sum       = g_st[STAGES-1].r_q;
  assign bus.cout      = g_st[STAGES-1].c_q;
  assign bus.ovf       = g_st[STAGES-1].g_last.ovf_q;

endmodule

// File: tb/tb_pipelined_addsub.sv
// tb_pipelined_addsub: directed checks of the 16-bit, 4-stage build.
// Arithmetic, flags, backpressure, bubbles and mid-flight reset.
module tb_pipelined_addsub;

  logic clk = 1'b0;
  logic rst_n;
  int   total = 0;
  int   bad = 0;

  addsub_if #(.WIDTH(16)) bus ();

  pipelined_addsub #(
    .WIDTH (16),
    .CHUNK (4)
  ) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s obs=%0h exp=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [17:0] model(input logic [15:0] x,
                                        input logic [15:0] y,
                                        input logic ci, input logic sb);
    logic [16:0] r;
    logic        c;
    logic        o;
    if (sb) begin
      r = {1'b0, x} - {1'b0, y};
      c = ~r[16];
      o = (x[15] != y[15]) && (r[15] != x[15]);
    end else begin
      r = {1'b0, x} + {1'b0, y} + {16'd0, ci};
      c = r[16];
      o = (x[15] == y[15]) && (r[15] != x[15]);
    end
    return {o, c, r[15:0]};
  endfunction

  task automatic run_op(input string tag, input logic [15:0] av,
                        input logic [15:0] bv, input logic ci,
                        input logic sb, input logic [15:0] es,
                        input logic ec, input logic eo);
    bus.a = av;
    bus.b = bv;
    bus.cin = ci;
    bus.sub = sb;
    bus.in_valid = 1'b1;
    bus.out_ready = 1'b1;
    @(posedge clk); #1;
    bus.in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk({tag, "_vld"}, 32'(bus.out_valid), 32'd1);
    chk({tag, "_sum"}, 32'(bus.sum), 32'(es));
    chk({tag, "_cout"}, 32'(bus.cout), 32'(ec));
    chk({tag, "_ovf"}, 32'(bus.ovf), 32'(eo));
  endtask

  logic [15:0] ra [10];
  logic [15:0] rb [10];
  logic        rc [10];
  logic        rs [10];
  logic [17:0] exp_q [$];
  int          pat [6] = '{1, 0, 1, 0, 0, 1};

  initial begin
    int sent;
    int got;
    int stall;
    int seen;
    bit stalled_once;

    rst_n = 1'b0;
    bus.in_valid = 1'b0;
    bus.a = '0;
    bus.b = '0;
    bus.cin = 1'b0;
    bus.sub = 1'b0;
    bus.out_ready = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    #1;

    chk("rst_vld", 32'(bus.out_valid), 32'd0);
    chk("rst_sum", 32'(bus.sum), 32'd0);
    chk("rst_cout", 32'(bus.cout), 32'd0);
    chk("rst_ovf", 32'(bus.ovf), 32'd0);
    chk("rst_rdy", 32'(bus.in_ready), 32'd1);
    @(posedge clk); #1;

    run_op("add_basic", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);
    run_op("add_wrap", 16'hFFFF, 16'h0001, 1'b0, 1'b0, 16'h0000, 1'b1, 1'b0);
    run_op("add_cin", 16'h000F, 16'h0000, 1'b1, 1'b0, 16'h0010, 1'b0, 1'b0);
    run_op("add_ovf", 16'h7FFF, 16'h0001, 1'b0, 1'b0, 16'h8000, 1'b0, 1'b1);
    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 1'b1, 16'hFFFE, 1'b0, 1'b0);
    run_op("sub_ovf", 16'h8000, 16'h0001, 1'b0, 1'b1, 16'h7FFF, 1'b1, 1'b1);
    run_op("sub_zero", 16'hA5A5, 16'hA5A5, 1'b0, 1'b1, 16'h0000, 1'b1, 1'b0);
    repeat (2) @(posedge clk);
    #1;
    chk("drain_vld", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 10; i++) begin
      ra[i] = 16'($urandom);
      rb[i] = 16'($urandom);
      rc[i] = 1'($urandom);
      rs[i] = 1'($urandom);
    end
    sent = 0;
    got = 0;
    stall = 0;
    stalled_once = 1'b0;
    for (int cyc = 0; cyc < 200 && got < 10; cyc++) begin
      if (bus.out_valid && !stalled_once) begin
        stalled_once = 1'b1;
        stall = 5;
      end
      bus.out_ready = (stall == 0);
      if (sent < 10) begin
        bus.a = ra[sent];
        bus.b = rb[sent];
        bus.cin = rc[sent];
        bus.sub = rs[sent];
        bus.in_valid = 1'b1;
      end else begin
        bus.in_valid = 1'b0;
      end
      #1;
      if (stall > 0) begin
        chk("stall_rdy", 32'(bus.in_ready), 32'd0);
        chk("stall_vld", 32'(bus.out_valid), 32'd1);
        if (exp_q.size() > 0)
          chk("stall_hold", 32'({bus.ovf, bus.cout, bus.sum}), 32'(exp_q[0]));
        stall--;
      end
      if (bus.out_valid && bus.out_ready) begin
        if (exp_q.size() == 0) begin
          chk("bp_extra", 32'd1, 32'd0);
        end else begin
          chk("bp_res", 32'({bus.ovf, bus.cout, bus.sum}),
              32'(exp_q.pop_front()));
        end
        got++;
      end
      if (bus.in_valid && bus.in_ready) begin
        exp_q.push_back(model(ra[sent], rb[sent], rc[sent], rs[sent]));
        sent++;
      end
      @(posedge clk); #1;
    end
    chk("bp_stalled", 32'(stalled_once), 32'd1);
    chk("bp_sent", 32'(sent), 32'd10);
    chk("bp_got", 32'(got), 32'd10);
    bus.in_valid = 1'b0;
    bus.out_ready = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    chk("bp_dup", 32'(bus.out_valid), 32'd0);

    for (int i = 0; i < 12; i++) begin
      chk($sformatf("bub_%0d", i), 32'(bus.out_valid),
          (i >= 4 && i < 10) ? 32'(pat[i-4]) : 32'd0);
      bus.in_valid = (i < 6) ? 1'(pat[i]) : 1'b0;
      bus.a = 16'(i);
      bus.b = 16'h0100;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      @(posedge clk); #1;
    end

    for (int i = 0; i < 3; i++) begin
      bus.a = 16'h1111 * 16'(i + 1);
      bus.b = 16'h0101;
      bus.cin = 1'b0;
      bus.sub = 1'b0;
      bus.in_valid = 1'b1;
      @(posedge clk); #1;
    end
    bus.in_valid = 1'b0;
    rst_n = 1'b0;
    @(posedge clk); #1;
    rst_n = 1'b1;
    chk("mrst_vld", 32'(bus.out_valid), 32'd0);
    chk("mrst_sum", 32'(bus.sum), 32'd0);
    chk("mrst_cout", 32'(bus.cout), 32'd0);
    seen = 0;
    for (int i = 0; i < 10; i++) begin
      @(posedge clk); #1;
      if (bus.out_valid) seen++;
    end
    chk("mrst_ghost", 32'(seen), 32'd0);

    run_op("post_rst", 16'h1234, 16'h4321, 1'b0, 1'b0, 16'h5555, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
